bitmap_encoder: RTL and testbench

BITMAP_ENCODER -- requirements
Module: bitmap_encoder

---
 rtl/bitmap_encoder.sv | 90 +++++++++
 tb/tb_bitmap_encoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_encoder.sv
// Bitmap-to-index encoder: accepts a 32-bit register-select bitmap and emits
// one set-bit index per beat, lowest-first or highest-first.
//
// state | meaning
// IDLE  | pending empty, ready to accept a bitmap
// EMIT  | pending nonzero, presenting one index per beat
module bitmap_encoder #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_bits,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [4:0]  out_index,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [5:0]  remaining
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [4:0]  sel_idx;
  logic [5:0]  pop_cnt;
  logic        emit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Priority select: the last assignment in the loop wins, so loop direction
  // picks lowest or highest set bit.
  always_comb begin
    sel_idx = '0;
    if (LSB_FIRST) begin
      for (int i = 31; i >= 0; i--)
        if (pending_q[i]) sel_idx = 5'(i);
    end else begin
      for (int i = 0; i < 32; i++)
        if (pending_q[i]) sel_idx = 5'(i);
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < 32; i++)
      pop_cnt = pop_cnt + {5'd0, pending_q[i]};
  end

  assign emit      = (state_q == EMIT);
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = emit;
  assign out_index = emit ? sel_idx : 5'd0;
  assign out_last  = emit && (pop_cnt == 6'd1);
  assign remaining = pop_cnt;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // A zero bitmap loads zero and stays IDLE, i.e. it is dropped.
          pending_d = in_bits;
          if (in_bits != 32'd0) state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = pending_q & ~(32'd1 << sel_idx);
          if (pop_cnt == 6'd1) state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bitmap_encoder.sv
// Bench for bitmap_encoder: two instances (LSB-first and MSB-first) share
// stimulus and are checked every cycle against index-queue models.
module tb_bitmap_encoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_bits = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_l, out_valid_l, out_last_l;
  logic [4:0]  out_index_l;
  logic [5:0]  remaining_l;
  logic        in_ready_m, out_valid_m, out_last_m;
  logic [4:0]  out_index_m;
  logic [5:0]  remaining_m;

  int tests = 0;
  int fails = 0;
  bit model_on = 1'b0;

  // Models: the ordered list of indices still to be emitted.
  int q_l[$];
  int q_m[$];

  always #5 clock = ~clock;

  bitmap_encoder #(.LSB_FIRST(1'b1)) dut_l (
    .clock(clock), .reset(reset), .in_bits(in_bits), .in_valid(in_valid),
    .in_ready(in_ready_l), .out_index(out_index_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_last(out_last_l), .remaining(remaining_l)
  );

  bitmap_encoder #(.LSB_FIRST(1'b0)) dut_m (
    .clock(clock), .reset(reset), .in_bits(in_bits), .in_valid(in_valid),
    .in_ready(in_ready_m), .out_index(out_index_m), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_last(out_last_m), .remaining(remaining_m)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      q_l.delete();
      q_m.delete();
    end else if (q_l.size() == 0) begin
      if (in_valid) begin
        for (int i = 0; i < 32; i++) if (in_bits[i]) q_l.push_back(i);
        for (int i = 31; i >= 0; i--) if (in_bits[i]) q_m.push_back(i);
      end
    end else if (out_ready) begin
      void'(q_l.pop_front());
      void'(q_m.pop_front());
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      chk("l_in_ready",  {31'd0, in_ready_l},  {31'd0, (q_l.size() == 0) && !reset});
      chk("l_out_valid", {31'd0, out_valid_l}, {31'd0, q_l.size() > 0});
      chk("l_out_index", {27'd0, out_index_l}, (q_l.size() > 0) ? q_l[0] : 0);
      chk("l_out_last",  {31'd0, out_last_l},  {31'd0, q_l.size() == 1});
      chk("l_remaining", {26'd0, remaining_l}, q_l.size());
      chk("m_in_ready",  {31'd0, in_ready_m},  {31'd0, (q_m.size() == 0) && !reset});
      chk("m_out_valid", {31'd0, out_valid_m}, {31'd0, q_m.size() > 0});
      chk("m_out_index", {27'd0, out_index_m}, (q_m.size() > 0) ? q_m[0] : 0);
      chk("m_out_last",  {31'd0, out_last_m},  {31'd0, q_m.size() == 1});
      chk("m_remaining", {26'd0, remaining_m}, q_m.size());
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic [31:0] bits, input logic rdy);
    in_bits = bits; in_valid = 1'b1; out_ready = rdy;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int low_cnt;
    int idx_seen;
    bit bad_idx;
    model_on = 1'b1;
    reset = 1'b1;
    in_valid = 1'b1; in_bits = 32'hFFFF_FFFF;
    step(); step();
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready_l}, 32'd0);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("post_rst_valid", {31'd0, out_valid_l}, 32'd0);
    chk("post_rst_rem", {26'd0, remaining_l}, 32'd0);
    chk("post_rst_ready", {31'd0, in_ready_l}, 32'd1);
    step();

    // 0x5: index 0 then 2 (LSB), 2 then 0 (MSB)
    accept(32'h0000_0005, 1'b1);
    @(negedge clock);
    chk("x5_b0_idx", {27'd0, out_index_l}, 32'd0);
    chk("x5_b0_rem", {26'd0, remaining_l}, 32'd2);
    chk("x5_b0_last", {31'd0, out_last_l}, 32'd0);
    chk("x5_b0_midx", {27'd0, out_index_m}, 32'd2);
    step();
    @(negedge clock);
    chk("x5_b1_idx", {27'd0, out_index_l}, 32'd2);
    chk("x5_b1_rem", {26'd0, remaining_l}, 32'd1);
    chk("x5_b1_last", {31'd0, out_last_l}, 32'd1);
    step();
    @(negedge clock);
    chk("x5_done_ready", {31'd0, in_ready_l}, 32'd1);
    step();

    // Full bitmap: 32 beats, in_ready low exactly 32 cycles
    accept(32'hFFFF_FFFF, 1'b1);
    low_cnt = 0; bad_idx = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (!in_ready_l) begin
        if (out_index_l != 5'(low_cnt)) bad_idx = 1'b1;
        if (out_last_l != (low_cnt == 31)) bad_idx = 1'b1;
        if (remaining_l != 6'(32 - low_cnt)) bad_idx = 1'b1;
        low_cnt++;
      end
      step();
    end
    chk("ffff_low_cycles", low_cnt, 32'd32);
    chk("ffff_sequence_ok", {31'd0, bad_idx}, 32'd0);

    // 0x80000001 with 3 stall cycles
    accept(32'h8000_0001, 1'b0);
    idx_seen = 0;
    for (int c = 0; c < 4; c++) begin
      out_ready = (c == 3);
      @(negedge clock);
      if (out_index_l == 5'd0 && remaining_l == 6'd2 && out_valid_l) idx_seen++;
      step();
    end
    chk("x8001_hold", idx_seen, 32'd4);
    @(negedge clock);
    chk("x8001_idx31", {27'd0, out_index_l}, 32'd31);
    chk("x8001_last", {31'd0, out_last_l}, 32'd1);
    step(); step();

    // Zero bitmap dropped
    accept(32'h0, 1'b1);
    @(negedge clock);
    chk("zero_valid", {31'd0, out_valid_l}, 32'd0);
    chk("zero_ready", {31'd0, in_ready_l}, 32'd1);
    chk("zero_rem", {26'd0, remaining_l}, 32'd0);
    step();

    // 0xF000, one beat, then reset abandons 13..15
    accept(32'h0000_F000, 1'b1);
    @(negedge clock);
    chk("f000_idx12", {27'd0, out_index_l}, 32'd12);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("f000_rst_valid", {31'd0, out_valid_l}, 32'd0);
    chk("f000_rst_rem", {26'd0, remaining_l}, 32'd0);
    chk("f000_rst_ready", {31'd0, in_ready_l}, 32'd1);
    for (int c = 0; c < 3; c++) step();

    // MSB-first order check on 0x00010010
    accept(32'h0001_0010, 1'b1);
    @(negedge clock);
    chk("msb_b0_idx", {27'd0, out_index_m}, 32'd16);
    chk("msb_b0_last", {31'd0, out_last_m}, 32'd0);
    step();
    @(negedge clock);
    chk("msb_b1_idx", {27'd0, out_index_m}, 32'd4);
    chk("msb_b1_last", {31'd0, out_last_m}, 32'd1);
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0: in_bits = 32'h0;
        1: in_bits = 32'd1 << $urandom_range(0, 31);
        2: in_bits = $urandom() & $urandom() & $urandom();
        default: in_bits = $urandom();
      endcase
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) < 2);
      step();
    end
    reset = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
